serial_flag_gen: RTL

- Multi-cycle producer of the ALU condition flags `z`, `v`, `n` that the compare stage consumes.
- Computes A − B as A + ~B + 1, LSB first, STEP bits per cycle.
- Used where a full-width combinational subtractor is too large or too slow, for example in a compact compare/branch path.
- Flag semantics: signed compares resolve as `n ^ v`; unsigned compares resolve as `n` with `v = 0`.

---
 rtl/alu_pkg.sv | 16 +
 rtl/sub_slice.sv | 18 +
 rtl/serial_flag_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial flag generator: FSM states, default sizing, Sign encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEP  = 4;

  localparam logic SIGN_UNSIGNED = 1'b0;
  localparam logic SIGN_SIGNED   = 1'b1;

endpackage

// File: rtl/sub_slice.sv
// Combinational STEP-bit adder slice with carry-in and carry-out.
module sub_slice #(
  parameter int STEP = 4
) (
  input  logic [STEP-1:0] i_a,
  input  logic [STEP-1:0] i_b,
  input  logic            i_cin,
  output logic [STEP-1:0] o_sum,
  output logic            o_cout
);

  logic [STEP:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{STEP{1'b0}}, i_cin};
  assign o_sum  = w_full[STEP-1:0];
  assign o_cout = w_full[STEP];

endmodule

// File: rtl/serial_flag_gen.sv
// Serial A-B (as A + ~B + 1), STEP bits per cycle, producing z/v/n compare flags.
// Optional FLAG_DIFF_OUT_EN adds the full difference on port S.
module serial_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sign,
  output logic             busy,
  output logic             done,
  output logic             z,
  output logic             v,
  output logic             n,
`ifdef FLAG_DIFF_OUT_EN
  output logic [WIDTH-1:0] S,
`endif
  output state_t           dbg_state
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_nb;
  logic             r_sign;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_carry;
  logic             r_zacc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_z;
  logic             r_v;
  logic             r_n;
`ifdef FLAG_DIFF_OUT_EN
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_s;
`endif

  logic [STEP-1:0]  w_sum;
  logic             w_cout;
  logic             w_last;
  logic             w_res_msb;
  logic             w_slice_nz;

  sub_slice #(.STEP(STEP)) u_slice (
    .i_a    (r_a[STEP-1:0]),
    .i_b    (r_nb[STEP-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_last     = (r_cnt == CW'(N - 1));
  assign w_res_msb  = w_sum[STEP-1];
  assign w_slice_nz = |w_sum;

  // Original operand MSBs are kept because the operand registers are shifted away during RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_nb    <= '0;
      r_sign  <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_z     <= 1'b0;
      r_v     <= 1'b0;
      r_n     <= 1'b0;
`ifdef FLAG_DIFF_OUT_EN
      r_res   <= '0;
      r_s     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_nb    <= ~B;
            r_sign  <= Sign;
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
            r_carry <= 1'b1;
            r_zacc  <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_carry <= w_cout;
          r_zacc  <= r_zacc | w_slice_nz;
          r_a     <= r_a >> STEP;
          r_nb    <= r_nb >> STEP;
          r_cnt   <= r_cnt + 1'b1;
`ifdef FLAG_DIFF_OUT_EN
          r_res   <= {w_sum, r_res[WIDTH-1:STEP]};
`endif
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_z     <= ~(r_zacc | w_slice_nz);
            if (r_sign == SIGN_SIGNED) begin
              r_n <= w_res_msb;
              r_v <= (r_a_msb != r_b_msb) && (w_res_msb != r_a_msb);
            end else begin
              r_n <= ~w_cout;
              r_v <= 1'b0;
            end
`ifdef FLAG_DIFF_OUT_EN
            r_s     <= {w_sum, r_res[WIDTH-1:STEP]};
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign z         = r_z;
  assign v         = r_v;
  assign n         = r_n;
  assign dbg_state = r_state;
`ifdef FLAG_DIFF_OUT_EN
  assign S         = r_s;
`endif

endmodule
